// File: rtl/paddle_logic.sv
// ---------------------------------------------------------------------------
// paddle_logic
//   Produces one paddle's left-edge X position on the playfield. Raw buttons
//   are synchronised (2 FF), debounced, and applied once per move tick. In
//   CPU mode the paddle steers towards the ball instead of following buttons.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   btn_left   raw left button (asynchronous, active-high)
//   btn_right  raw right button (asynchronous, active-high)
//   cpu_mode   1 = track ballX, 0 = buttons drive the paddle
//   ballX      current ball X position (0..127)
//   paddleX    paddle left edge, always within 0..MAXPOS
//   move_tick  one-cycle pulse following each paddle update edge
//   left_db    debounced btn_left
//   right_db   debounced btn_right
// ---------------------------------------------------------------------------
module paddle_logic #(
    parameter int CLK_HZ   = 10_000_000,
    parameter int MOVE_HZ  = 100,
    parameter int DEB_HZ   = 1000,
    parameter int FIELD_W  = 128,
    parameter int PADDLE_W = 16,
    parameter int STEP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       cpu_mode,
    input  logic [6:0] ballX,
    output logic [6:0] paddleX,
    output logic       move_tick,
    output logic       left_db,
    output logic       right_db
);

    localparam int CUENTA  = CLK_HZ / MOVE_HZ;
    localparam int DEB_CNT = CLK_HZ / DEB_HZ;
    localparam int MAXPOS  = FIELD_W - PADDLE_W;
    localparam int CW      = (CUENTA > 1)  ? $clog2(CUENTA)  : 1;
    localparam int DW      = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam int AW      = 10;    // signed working width, room for ballX - PADDLE_W/2 and +/-STEP

    localparam logic [CW-1:0]        CONT_LAST = CW'(CUENTA - 1);
    localparam logic [DW-1:0]        DC_LAST   = DW'(DEB_CNT - 1);
    localparam logic [6:0]           POS_RST   = 7'(MAXPOS / 2);
    localparam logic signed [AW-1:0] S_MAX     = AW'(MAXPOS);
    localparam logic signed [AW-1:0] S_STEP    = AW'(STEP);
    localparam logic signed [AW-1:0] S_HALF    = AW'(PADDLE_W / 2);

    // ------------------------------------------------------------------
    // Button synchronisers: bit 0 = left, bit 1 = right
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] db_vec;

    assign btn_raw = {btn_right, btn_left};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers: db follows s only after s has differed from db for
    // DEB_CNT consecutive clocks; any agreement restarts the count.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic [DW-1:0] dc_q, dc_d;
            logic          db_q, db_d;

            always_comb begin
                dc_d = dc_q;
                db_d = db_q;
                if (sync2_q[gi] == db_q) begin
                    dc_d = '0;
                end else if (dc_q == DC_LAST) begin
                    db_d = sync2_q[gi];
                    dc_d = '0;
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dc_q <= '0;
                    db_q <= 1'b0;
                end else begin
                    dc_q <= dc_d;
                    db_q <= db_d;
                end
            end

            assign db_vec[gi] = db_q;
        end
    endgenerate

    assign left_db  = db_vec[0];
    assign right_db = db_vec[1];

    // ------------------------------------------------------------------
    // Move-tick divider
    // ------------------------------------------------------------------
    logic [CW-1:0] cont_q, cont_d;
    logic          move_tick_q, move_tick_d;
    logic          update_edge;

    always_comb begin
        update_edge = (cont_q == CONT_LAST);
        cont_d      = update_edge ? '0 : cont_q + 1'b1;
        move_tick_d = update_edge;
    end

    // ------------------------------------------------------------------
    // Next paddle position. Every branch lands inside 0..MAXPOS, so the
    // 7-bit truncation never loses information.
    // ------------------------------------------------------------------
    logic [6:0]           paddle_q, paddle_d;
    logic [6:0]           next_pos;
    logic signed [AW-1:0] pos_s, ball_s, target_s, diff_s;

    always_comb begin
        pos_s    = {3'b000, paddle_q};
        ball_s   = {3'b000, ballX};
        target_s = ball_s - S_HALF;
        if (target_s < 0) begin
            target_s = '0;
        end else if (target_s > S_MAX) begin
            target_s = S_MAX;
        end
        diff_s   = target_s - pos_s;
        next_pos = paddle_q;

        if (cpu_mode) begin
            // Land exactly on the target when within one step: no overshoot.
            if (diff_s > 0) begin
                next_pos = (diff_s > S_STEP) ? 7'(pos_s + S_STEP) : 7'(target_s);
            end else if (diff_s < 0) begin
                next_pos = (-diff_s > S_STEP) ? 7'(pos_s - S_STEP) : 7'(target_s);
            end
        end else if (left_db && !right_db) begin
            next_pos = (pos_s >= S_STEP) ? 7'(pos_s - S_STEP) : 7'd0;
        end else if (right_db && !left_db) begin
            next_pos = (pos_s <= S_MAX - S_STEP) ? 7'(pos_s + S_STEP) : 7'(S_MAX);
        end

        paddle_d = update_edge ? next_pos : paddle_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_q      <= '0;
            move_tick_q <= 1'b0;
            paddle_q    <= POS_RST;
        end else begin
            cont_q      <= cont_d;
            move_tick_q <= move_tick_d;
            paddle_q    <= paddle_d;
        end
    end

    assign paddleX   = paddle_q;
    assign move_tick = move_tick_q;

endmodule

// File: doc/paddle_logic.md
Name: paddle_logic

Overview:
Produces one paddle's horizontal position (left edge, 7-bit) on the 128-wide playfield. The ball/collision logic consumes this as firstPos/secondPos, and the top level instantiates the block once per player. Raw push-buttons are synchronised, debounced and applied on a fixed-rate move tick. An optional CPU mode tracks ballX instead.

Parameters:
CLK_HZ, 10_000_000, system clock frequency in Hz
MOVE_HZ, 100, paddle update rate; CUENTA = CLK_HZ/MOVE_HZ clocks per move tick
DEB_HZ, 1000, debounce window; DEB_CNT = CLK_HZ/DEB_HZ stable clocks required
FIELD_W, 128, playfield width in pixels
PADDLE_W, 16, paddle width in pixels; MAXPOS = FIELD_W-PADDLE_W (112)
STEP, 1, pixels moved per move tick

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
btn_left  in  1  raw button, asynchronous to clk, active-high
btn_right  in  1  raw button, asynchronous to clk, active-high
cpu_mode  in  1  1 = paddle tracks ballX; 0 = buttons control paddle
ballX  in  7  current ball X (0..127)
paddleX  out  7  paddle left-edge position, 0..MAXPOS
move_tick  out  1  one-cycle pulse at each paddle update (debug/visibility)
left_db  out  1  debounced btn_left
right_db  out  1  debounced btn_right

Behaviour:
- Reset (async, rst=1): paddleX=MAXPOS/2 (56), left_db=right_db=0, move_tick=0, synchronisers and all counters cleared. Reset mid-tick or mid-debounce discards the partial count.
- Synchroniser: 2-FF chain per button. Only the second FF output (s) is used downstream.
- Debounce, one per button:
  - Counter dc counts clocks while s != db.
  - dc clears to 0 on any clock where s == db.
  - When dc reaches DEB_CNT-1 with s still != db, db <= s and dc <= 0 on the same edge.
  - Net latency from a clean raw edge to the db change: 2 sync clocks + DEB_CNT clocks.
  - A glitch shorter than DEB_CNT clocks never changes db.
- Tick divider:
  - cont counts 0..CUENTA-1, then wraps to 0.
  - move_tick is registered and high for exactly the one cycle after cont==CUENTA-1.
  - paddleX updates only on the edge where cont==CUENTA-1. Otherwise paddleX holds.
- Human mode (cpu_mode=0), evaluated at the update edge using current left_db/right_db:
  - left only: paddleX <= (paddleX>=STEP) ? paddleX-STEP : 0
  - right only: paddleX <= (paddleX<=MAXPOS-STEP) ? paddleX+STEP : MAXPOS
  - both or neither: hold.
- CPU mode (cpu_mode=1), evaluated at the update edge:
  - target = ballX - PADDLE_W/2, clamped to 0..MAXPOS. Compute in 9-bit signed; negative results clamp to 0.
  - diff = target - paddleX.
  - diff>0: paddleX += min(STEP, diff). diff<0: paddleX -= min(STEP, -diff). diff=0: hold. No overshoot.
  - Buttons are ignored, but debouncers keep running.
- cpu_mode is sampled only at the update edge. Toggling it does not reset cont or paddleX.
- Invariant: paddleX never exceeds MAXPOS and never wraps below 0, for any STEP from 1 to MAXPOS.
- All internal arithmetic is at least 9 bits signed. The output is the low 7 bits after clamping.

Test Plan:
Sim params for all cases: CLK_HZ=1000, MOVE_HZ=100, DEB_HZ=250, giving CUENTA=10 and DEB_CNT=4.
1. Reset: assert rst asynchronously mid-count, no clock edge -> paddleX=56, left_db=0, move_tick=0 immediately. Release -> first move_tick exactly 10 clocks later.
2. Debounce: btn_right pulse of 3 clocks -> right_db stays 0. Hold btn_right high -> right_db=1 at raw edge +6 clocks. Then paddleX goes 56->57->58 on successive ticks.
3. Clamp: hold btn_left from paddleX=2 with STEP=3 -> next tick paddleX=0, then stays 0. Hold btn_right near the top -> saturates at 112, never 113+.
4. Both buttons: left_db=right_db=1 for 5 ticks -> paddleX unchanged at 56.
5. CPU tracking: cpu_mode=1, ballX=100 -> target 92; paddleX rises by 1 per tick from 56 and reaches 92 after 36 ticks, then holds. ballX=3 -> target clamps to 0 and paddleX decreases to 0. STEP=5 with diff=2 -> moves exactly 2.
6. Mode switch: toggle cpu_mode mid-tick with buttons held -> cont keeps counting (tick period still 10), and the new mode takes effect at the next update edge only.
